// File: rtl/data_mem_responder.sv
// Single-port data memory for the processor DM port: registered read-first
// access, with an optional post-reset zeroing pass enabled by DMEM_CLEAR_EN.
module data_mem_responder #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ena,
    input  logic              wea,
    input  logic [ADDR_W-1:0] addra,
    input  logic [DATA_W-1:0] dina,
    output logic [DATA_W-1:0] douta,
    output logic              ready,
    output logic              access_err
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              acc;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

`ifdef DMEM_CLEAR_EN
    typedef enum logic {CLEAR, IDLE} state_t;

    state_t            state;
    logic [ADDR_W-1:0] clr_ptr;
    logic              ready_q;
    logic              err_q;

    // clr_ptr wraps back to 0 on the last word, so it rests at 0 in IDLE
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= CLEAR;
            clr_ptr <= '0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            case (state)
                CLEAR: begin
                    err_q   <= ena;
                    clr_ptr <= clr_ptr + 1'b1;
                    if (clr_ptr == {ADDR_W{1'b1}}) begin
                        state   <= IDLE;
                        ready_q <= 1'b1;
                    end
                end
                default: err_q <= 1'b0;
            endcase
        end
    end

    assign ready      = ready_q;
    assign access_err = err_q;
    assign acc        = ena & (state == IDLE);

    // The clearing pass owns the write port; processor accesses are dropped
    always_comb begin
        if (state == CLEAR) begin
            wr_en   = 1'b1;
            wr_addr = clr_ptr;
            wr_data = '0;
        end else begin
            wr_en   = acc & wea;
            wr_addr = addra;
            wr_data = dina;
        end
    end
`else
    assign ready      = 1'b1;
    assign access_err = 1'b0;
    assign acc        = ena;
    assign wr_en      = ena & wea;
    assign wr_addr    = addra;
    assign wr_data    = dina;
`endif

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_addr] <= wr_data;
    end

    // Read-first: a write cycle also loads the pre-write word into douta
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            douta <= '0;
        else if (acc)
            douta <= mem[addra];
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder; clear-sequence scenarios are
// included when DMEM_CLEAR_EN is defined.
module tb_data_mem_responder;
    localparam int AW = 7;
    localparam int DW = 32;
`ifdef DMEM_CLEAR_EN
    localparam bit CLR = 1'b1;
`else
    localparam bit CLR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          ena = 1'b0;
    logic          wea = 1'b0;
    logic [AW-1:0] addra = '0;
    logic [DW-1:0] dina = '0;
    logic [DW-1:0] douta;
    logic          ready;
    logic          access_err;

    always #5 clk = ~clk;

    data_mem_responder #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst), .ena(ena), .wea(wea), .addra(addra),
        .dina(dina), .douta(douta), .ready(ready), .access_err(access_err)
    );

    typedef struct {
        logic [DW-1:0] d;
        logic          rdy;
        logic          err;
        string         name;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   checks = 0;
    int   errors = 0;
    logic chk_req = 1'b0;
    logic chk_d = 1'b0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: results of a checked access are visible one edge after sampling
    always @(posedge clk) chk_d <= chk_req;

    always @(negedge clk) begin
        if (chk_d) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL scoreboard_underflow: got empty queue expected entry");
            end else begin
                e = q.pop_front();
                check({e.name, "_douta"}, douta, e.d);
                check({e.name, "_ready"}, {31'd0, ready}, {31'd0, e.rdy});
                check({e.name, "_err"}, {31'd0, access_err}, {31'd0, e.err});
            end
        end
    end

    task automatic cyc(input logic en, input logic we, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input bit chk, input logic [DW-1:0] ed,
                       input logic er, input logic ee, input string nm);
        exp_t x;
        @(posedge clk); #1;
        ena = en; wea = we; addra = a; dina = d; chk_req = chk;
        if (chk) begin
            x.d = ed; x.rdy = er; x.err = ee; x.name = nm;
            q.push_back(x);
        end
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
        cyc(1'b1, 1'b1, a, d, 1'b0, '0, 1'b1, 1'b0, "");
    endtask

    task automatic rd(input logic [AW-1:0] a, input logic [DW-1:0] ed, input string nm);
        cyc(1'b1, 1'b0, a, '0, 1'b1, ed, 1'b1, 1'b0, nm);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            ena = 1'b0; wea = 1'b0; chk_req = 1'b0;
        end
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (!ready && n < 1000) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic assert_rst(input string nm);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check({nm, "_douta"}, douta, '0);
        check({nm, "_err"}, {31'd0, access_err}, '0);
        check({nm, "_ready"}, {31'd0, ready}, {31'd0, !CLR});
    endtask

    int n;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #2 rst = 1'b0;
        #1;
        check("rst_douta", douta, '0);
        check("rst_err", {31'd0, access_err}, '0);
        check("rst_ready", {31'd0, ready}, {31'd0, !CLR});
        #20;
        @(negedge clk) rst = 1'b1;

        if (CLR) begin
            wait_ready(n);
            check("ready_after_clear", n, 128);
            rd(7'h00, 32'h0, "clr_rd00");
            rd(7'h7F, 32'h0, "clr_rd7F");
        end else begin
            idle(1);
        end

        wr(7'h05, 32'hDEADBEEF);
        rd(7'h05, 32'hDEADBEEF, "rd05");

        wr(7'h0A, 32'h11111111);
        cyc(1'b1, 1'b1, 7'h0A, 32'h22222222, 1'b1, 32'h11111111, 1'b1, 1'b0, "rdfirst0A");
        rd(7'h0A, 32'h22222222, "rd0A");

        wr(7'h01, 32'hA5A5A5A5);
        wr(7'h02, 32'h0BADF00D);
        rd(7'h01, 32'hA5A5A5A5, "b2b_rd01");
        cyc(1'b1, 1'b1, 7'h02, 32'hCAFEF00D, 1'b1, 32'h0BADF00D, 1'b1, 1'b0, "b2b_wr02");
        rd(7'h02, 32'hCAFEF00D, "b2b_rd02");

        cyc(1'b0, 1'b1, 7'h05, 32'hFFFFFFFF, 1'b1, 32'hCAFEF00D, 1'b1, 1'b0, "hold_we");
        cyc(1'b0, 1'b0, 7'h0A, 32'h0, 1'b1, 32'hCAFEF00D, 1'b1, 1'b0, "hold_rd");
        rd(7'h05, 32'hDEADBEEF, "noen_nowrite05");

        wr(7'h7F, 32'h80000001);
        wr(7'h00, 32'h00000080);
        rd(7'h7F, 32'h80000001, "rd7F");
        rd(7'h00, 32'h00000080, "rd00");
        idle(3);

        if (CLR) begin
            // Reset in the middle of a clear restarts the full pass
            assert_rst("rst2");
            @(negedge clk) rst = 1'b1;
            repeat (60) @(posedge clk);
            assert_rst("rst_midclear");
            @(negedge clk) rst = 1'b1;
            wait_ready(n);
            check("ready_after_restart", n, 128);
            wr(7'h03, 32'h77777777);
            rd(7'h03, 32'h77777777, "rd03_pre");
            idle(3);

            assert_rst("rst3");
            @(negedge clk) rst = 1'b1;
            repeat (10) @(posedge clk);
            cyc(1'b1, 1'b1, 7'h03, 32'hFFFFFFFF, 1'b1, 32'h0, 1'b0, 1'b1, "drop_wr");
            cyc(1'b0, 1'b0, 7'h03, 32'h0, 1'b1, 32'h0, 1'b0, 1'b0, "err_pulse");
            idle(1);
            wait_ready(n);
            check("ready_after_drop", {31'd0, ready}, 32'd1);
            rd(7'h03, 32'h0, "rd03_cleared");
            rd(7'h05, 32'h0, "rd05_cleared");
            idle(3);
        end

        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_leftover: got %0d entries expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter ADDR_W, 7, word-address width; SHALL size the array at 2**ADDR_W words.
REQ-002 Parameter DATA_W, 32, word width in bits.
REQ-003 clk  input  1  single clock; all state changes on rising edge; the system ties DMclka to this clock.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 ena  input  1  access enable from the processor DM port.
REQ-006 wea  input  1  write enable; meaningful only while ena=1.
REQ-007 addra  input  ADDR_W  word address.
REQ-008 dina  input  DATA_W  write data.
REQ-009 douta  output  DATA_W  registered read data.
REQ-010 ready  output  1  high when the array accepts accesses.
REQ-011 access_err  output  1  one-cycle pulse flagging an access attempted while ready=0.

Function
REQ-012 The FSM SHALL have states CLEAR and IDLE; reset enters CLEAR (macro on) or IDLE (macro off).
REQ-013 In CLEAR, the block SHALL write 0 to word clr_ptr each cycle, clr_ptr counting 0..2**ADDR_W-1.
REQ-014 After the write to the last word, the FSM SHALL go to IDLE, with ready=1 from the next cycle.
REQ-015 In IDLE, with ena=1 and wea=1, mem[addra] SHALL take dina at the clock edge.
REQ-016 In IDLE, with ena=1 and wea=0, douta SHALL present mem[addra] exactly one cycle after the edge that sampled the address.
REQ-017 A write SHALL be read-first: during a write, douta SHALL load the old mem[addra].
REQ-018 With ena=0, douta SHALL hold its last value and the array SHALL be unchanged.
REQ-019 With ready=0 and ena=1, the access SHALL be dropped (no write, douta held) and access_err SHALL be 1 the next cycle.
REQ-020 addra SHALL use all ADDR_W bits; there is no out-of-range address and no wrap is required.
REQ-021 Back-to-back accesses on consecutive cycles SHALL each complete at full rate with no bubble.

Reset
REQ-022 Asserting rst SHALL immediately set douta=0, access_err=0, clr_ptr=0, and ready=0 (macro on) or ready=1 (macro off).
REQ-023 Reset asserted during CLEAR SHALL restart the clear from word 0.
REQ-024 Reset SHALL NOT touch array contents, other than through the clear sequence.
REQ-025 Release of rst SHALL take effect on the first rising clk edge after deassertion.

Configuration
REQ-026 With macro DMEM_CLEAR_EN defined, the CLEAR state SHALL be compiled in: 2**ADDR_W cycles of zeroing after every reset, with ready=0 throughout.
REQ-027 Without DMEM_CLEAR_EN, the CLEAR state and clr_ptr SHALL be absent, and ready SHALL be tied to 1.
REQ-028 Without DMEM_CLEAR_EN, access_err SHALL be tied to 0 and contents after reset are undefined.

Verification
REQ-029 Macro on, release rst, hold ena=0 -> ready=0 for 128 cycles, then 1; reading addr 0x00 and 0x7F returns 0x00000000.
REQ-030 Write 0xDEADBEEF to 0x05, then read 0x05 on the next cycle -> douta=0xDEADBEEF one cycle after the read edge.
REQ-031 Write 0x11111111 to 0x0A, then write 0x22222222 to 0x0A -> douta=0x11111111 after the second write (read-first); a following read gives 0x22222222.
REQ-032 Macro on, ena=1 wea=1 at cycle 10 of CLEAR -> access_err=1 for one cycle; once ready, that address reads 0.
REQ-033 Assert rst at clear cycle 60, release -> ready stays low a full 128 cycles; douta=0 immediately on assertion.
REQ-034 Alternate read 0x01 / write 0x02 / read 0x02 on consecutive cycles -> each result appears one cycle later, with no stalls.
